dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the byte-addressed, little-endian data memory (1024 bytes, combinational read, write committed on the clock edge). It sits between the pipeline MEM stage (requester 0) and a secondary master such as a debug/DMA port (requester 1). It owns the memory's address/enable/data/size pins, grants fairly by round-robin, and returns each result over a per-requester valid/ready response channel. Transfers may be rejected as errors before they reach memory.

## Interface
- `DATA_MEM_SIZE`, 1024: memory size in bytes; must be a power of two greater than 8.
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `rN_req_valid` in 1 (N=0,1): requester N presents a request.
- `rN_req_ready` out 1: request accepted this cycle.
- `rN_req_we` in 1: 1 = write, 0 = read.
- `rN_req_addr` in 64: byte address.
- `rN_req_wdata` in 64: write data, little-endian, low `size` bytes used.
- `rN_req_size` in 4: transfer bytes; legal values are 1, 2, 4 or 8.
- `rN_resp_valid` out 1: response available.
- `rN_resp_ready` in 1: requester consumes the response.
- `rN_resp_rdata` out 64: read data; low `size` bytes valid, upper bytes zero; 0 for writes.
- `rN_resp_err` out 1: request rejected; memory not touched.
- `mem_address` out 64, `mem_write_data` out 64, `mem_xfer_size` out 4: registered memory controls.
- `mem_write_enable`, `mem_read_enable` out 1: memory strobes, registered.
- `mem_read_data` in 64: combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not granted last (`last_grant` pointer).
  - `rN_req_ready` is combinational and asserted only for the granted requester, and only in IDLE.
  - On acceptance, latch `we`, `addr`, `wdata`, `size` and the owner, and set `last_grant` to the owner.
  - Next state is ACCESS, or RESP with the error flag set if the request is illegal (see Configuration).
- ACCESS:
  - Exactly one cycle; `mem_*` drive the latched request.
  - `mem_read_enable` = !we; `mem_write_enable` = we.
  - For reads, the low `size` bytes of `mem_read_data` are registered at the end-of-cycle edge; the upper bytes are zeroed.
  - A write commits at that same edge.
  - Next state is RESP.
- RESP:
  - Only the owner's `resp_valid` = 1; `rdata` and `err` are held stable.
  - On `resp_valid && resp_ready`, go to IDLE.
  - Requests are not accepted in RESP. No pipelining: at most one transaction is in flight.
- Outside ACCESS, both strobes are 0, and `mem_address`/`mem_write_data`/`mem_xfer_size` hold their last values.

## Timing
- Request handshake at edge T. ACCESS is the cycle after T; `resp_valid` rises in the cycle after ACCESS, i.e. two cycles after acceptance.
- With `resp_ready` held at 1: 3 cycles per transaction, and the next acceptance comes the cycle after the response handshake.
- Error path: `resp_valid` rises the cycle after acceptance, with no ACCESS cycle and no strobes.
- Reset values:
  - state = IDLE; `last_grant` = 1, so requester 0 wins the first tie.
  - All `req_ready`, `resp_valid`, `resp_err`, `mem_*_enable` = 0.
  - `resp_rdata` = 0, `mem_address` = 0, `mem_write_data` = 0, `mem_xfer_size` = 8.
- Reset mid-operation:
  - Asserting `reset` during ACCESS drops `mem_write_enable` immediately (asynchronous); no write commits at the following edge.
  - A pending response is discarded, and requesters must reissue.
- A requester that deasserts `req_valid` before being granted is simply not served.
- `resp_ready` asserted while `resp_valid` = 0 is ignored.

## Configuration
- `DMEM_ARB_CHECK_EN` defined: on acceptance, the request is flagged an error if any of these hold:
  - `size` is not in {1,2,4,8};
  - `addr & (size-1)` is nonzero;
  - `addr + size > DATA_MEM_SIZE`.
- An errored request goes IDLE→RESP with `err` = 1 and `rdata` = 0, and never strobes memory.
- `DMEM_ARB_CHECK_EN` undefined:
  - No checking; `rN_resp_err` is tied to 0.
  - Every accepted request passes through ACCESS, and memory handles bad accesses itself.

## Test plan
- Reset, then requester 0 writes addr 16, size 8, data 0x0123456789ABCDEF. Then requester 0 reads addr 16, size 8 → `rdata` = 0x0123456789ABCDEF, `err` = 0, `resp_valid` two cycles after the read handshake.
- Requester 1 reads addr 18, size 2 after the previous write → `rdata` = 0x0000000000008BCD? No: bytes 18–19 hold 0xAB, 0x89, so `rdata` = 0x89AB.
- Both requesters valid continuously for 6 transactions → grants alternate 0,1,0,1,0,1. Only the owner sees `resp_valid`.
- With `DMEM_ARB_CHECK_EN`:
  - read addr 3, size 2 → `err` = 1, `rdata` = 0, no strobe;
  - read addr 1020, size 8 → `err` = 1;
  - size 3 → `err` = 1.
- Without `DMEM_ARB_CHECK_EN`, the same addr-1020 request → `err` = 0 and ACCESS strobe asserted.
- Hold `resp_ready` = 0 for 5 cycles → `resp_valid`/`rdata` held stable, the other requester's `req_ready` stays 0.
- Assert `reset` during the ACCESS cycle of a write of 0xFF to addr 40 → strobe drops at once, a later read of addr 40 returns its prior value, and all outputs are at reset values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-requester sequencer for the byte-addressed data memory.
// Define DMEM_ARB_CHECK_EN to reject misaligned, out-of-range or bad-size requests.
module dmem_arbiter #(
    parameter int DATA_MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req_valid,
    output logic        r0_req_ready,
    input  logic        r0_req_we,
    input  logic [63:0] r0_req_addr,
    input  logic [63:0] r0_req_wdata,
    input  logic [3:0]  r0_req_size,
    output logic        r0_resp_valid,
    input  logic        r0_resp_ready,
    output logic [63:0] r0_resp_rdata,
    output logic        r0_resp_err,
    input  logic        r1_req_valid,
    output logic        r1_req_ready,
    input  logic        r1_req_we,
    input  logic [63:0] r1_req_addr,
    input  logic [63:0] r1_req_wdata,
    input  logic [3:0]  r1_req_size,
    output logic        r1_resp_valid,
    input  logic        r1_resp_ready,
    output logic [63:0] r1_resp_rdata,
    output logic        r1_resp_err,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [63:0] mem_read_data
);

    if (DATA_MEM_SIZE <= 8 || (DATA_MEM_SIZE & (DATA_MEM_SIZE - 1)) != 0) begin : g_size_chk
        $error("DATA_MEM_SIZE must be a power of two greater than 8");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        last_grant;
    logic        owner;
    logic        rv0;
    logic        rv1;
    logic [63:0] rdata_q;
    logic        gnt0;
    logic        gnt1;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [3:0]  sel_size;
    logic [63:0] rmask;
    logic        bad;

    // Round-robin grant: a tie goes to the requester not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            gnt0 = r0_req_valid && (!r1_req_valid || last_grant);
            gnt1 = r1_req_valid && (!r0_req_valid || !last_grant);
        end
    end

    assign r0_req_ready = gnt0;
    assign r1_req_ready = gnt1;

    // Mux the granted requester's fields.
    always_comb begin
        sel_we    = gnt1 ? r1_req_we    : r0_req_we;
        sel_addr  = gnt1 ? r1_req_addr  : r0_req_addr;
        sel_wdata = gnt1 ? r1_req_wdata : r0_req_wdata;
        sel_size  = gnt1 ? r1_req_size  : r0_req_size;
    end

    // Keep only the low xfer_size bytes of the memory read data.
    always_comb begin
        rmask = '0;
        for (int i = 0; i < 8; i++) begin
            rmask[8*i +: 8] = (4'(i) < mem_xfer_size) ? 8'hFF : 8'h00;
        end
    end

`ifdef DMEM_ARB_CHECK_EN
    logic        err_q;
    logic [64:0] end_addr;

    // Flag bad size, misalignment, or a transfer running past the memory end.
    always_comb begin
        end_addr = {1'b0, sel_addr} + 65'(sel_size);
        bad = !(sel_size == 4'd1 || sel_size == 4'd2 ||
                sel_size == 4'd4 || sel_size == 4'd8) ||
              (|(sel_addr & (64'(sel_size) - 64'd1))) ||
              (end_addr > 65'(DATA_MEM_SIZE));
    end

    assign r0_resp_err = err_q && !owner;
    assign r1_resp_err = err_q && owner;
`else
    assign bad         = 1'b0;
    assign r0_resp_err = 1'b0;
    assign r1_resp_err = 1'b0;
`endif

    assign r0_resp_valid = rv0;
    assign r1_resp_valid = rv1;
    assign r0_resp_rdata = rdata_q;
    assign r1_resp_rdata = rdata_q;

    // Sequencer: accept in IDLE, strobe memory for one cycle, hold the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            rv0              <= 1'b0;
            rv1              <= 1'b0;
            rdata_q          <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_xfer_size    <= 4'd8;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
`ifdef DMEM_ARB_CHECK_EN
            err_q            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        if (bad) begin
                            rdata_q <= '0;
                            rv0     <= gnt0;
                            rv1     <= gnt1;
                            state   <= RESP;
                        end else begin
                            mem_address      <= sel_addr;
                            mem_write_data   <= sel_wdata;
                            mem_xfer_size    <= sel_size;
                            mem_write_enable <= sel_we;
                            mem_read_enable  <= !sel_we;
                            state            <= ACCESS;
                        end
`ifdef DMEM_ARB_CHECK_EN
                        err_q <= bad;
`endif
                    end
                end
                ACCESS: begin
                    mem_write_enable <= 1'b0;
                    mem_read_enable  <= 1'b0;
                    rdata_q <= mem_write_enable ? 64'd0 : (mem_read_data & rmask);
                    rv0     <= !owner;
                    rv1     <= owner;
                    state   <= RESP;
                end
                RESP: begin
                    if ((rv0 && r0_resp_ready) || (rv1 && r1_resp_ready)) begin
                        rv0   <= 1'b0;
                        rv1   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench for dmem_arbiter.
// Includes a 1 KiB behavioural memory and a byte-array shadow model.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic [3:0]  req_size [2];
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_rdata [2];
    logic [1:0]  resp_err;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic [3:0]  mem_xfer_size;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [63:0] mem_read_data;

    logic [7:0]  mem [1024];
    logic [7:0]  shadow [1024];
    logic        model_last;
    int          n_checks;
    int          n_fail;

    dmem_arbiter #(.DATA_MEM_SIZE(1024)) dut (
        .clk(clk),
        .reset(reset),
        .r0_req_valid(req_valid[0]),
        .r0_req_ready(req_ready[0]),
        .r0_req_we(req_we[0]),
        .r0_req_addr(req_addr[0]),
        .r0_req_wdata(req_wdata[0]),
        .r0_req_size(req_size[0]),
        .r0_resp_valid(resp_valid[0]),
        .r0_resp_ready(resp_ready[0]),
        .r0_resp_rdata(resp_rdata[0]),
        .r0_resp_err(resp_err[0]),
        .r1_req_valid(req_valid[1]),
        .r1_req_ready(req_ready[1]),
        .r1_req_we(req_we[1]),
        .r1_req_addr(req_addr[1]),
        .r1_req_wdata(req_wdata[1]),
        .r1_req_size(req_size[1]),
        .r1_resp_valid(resp_valid[1]),
        .r1_resp_ready(resp_ready[1]),
        .r1_resp_rdata(resp_rdata[1]),
        .r1_resp_err(resp_err[1]),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_xfer_size(mem_xfer_size),
        .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on the clock edge.
    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            mem_read_data[8*i +: 8] = mem[10'(mem_address[9:0] + 10'(i))];
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < mem_xfer_size) begin
                    mem[10'(mem_address[9:0] + 10'(i))] <= mem_write_data[8*i +: 8];
                end
            end
        end
    end

    function automatic logic [63:0] model_read(input int a, input int sz);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < sz; i++) r[8*i +: 8] = shadow[(a + i) % 1024];
        return r;
    endfunction

    task automatic model_write(input int a, input int sz, input logic [63:0] d);
        for (int i = 0; i < sz; i++) shadow[(a + i) % 1024] = d[8*i +: 8];
    endtask

    task automatic set_req(input int n, input bit we, input logic [63:0] a,
                           input logic [63:0] wd, input logic [3:0] sz);
        req_we[n]    = we;
        req_addr[n]  = a;
        req_wdata[n] = wd;
        req_size[n]  = sz;
    endtask

    // One full transaction on requester n, returning what was observed.
    task automatic xfer(input int n, input bit we, input logic [63:0] a,
                        input logic [63:0] wd, input logic [3:0] sz,
                        output logic [63:0] rd, output bit er, output int lat,
                        output bit strobe, output bit to);
        int k;
        to = 1'b0; lat = -1; strobe = 1'b0; rd = '0; er = 1'b0;
        set_req(n, we, a, wd, sz);
        req_valid[n] = 1'b1;
        #1;
        k = 0;
        while (!req_ready[n] && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!req_ready[n]) begin
            to = 1'b1; req_valid[n] = 1'b0; return;
        end
        @(posedge clk); #1;
        req_valid[n] = 1'b0;
        strobe = mem_read_enable | mem_write_enable;
        lat = 0;
        while (!resp_valid[n] && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_valid[n]) begin
            to = 1'b1; return;
        end
        rd = resp_rdata[n];
        er = resp_err[n];
        resp_ready[n] = 1'b1;
        @(posedge clk); #1;
        resp_ready[n] = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_err !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b rv=%b err=%b, want 00/00/00",
                     req_ready, resp_valid, resp_err);
        end
        n_checks++;
        if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: we=%b re=%b, want 0/0", mem_write_enable, mem_read_enable);
        end
        n_checks++;
        if (mem_address !== 64'd0 || mem_write_data !== 64'd0 || mem_xfer_size !== 4'd8) begin
            n_fail++;
            $display("FAIL reset_mem: addr=%h wd=%h sz=%0d, want 0/0/8",
                     mem_address, mem_write_data, mem_xfer_size);
        end
        n_checks++;
        if (resp_rdata[0] !== 64'd0 || resp_rdata[1] !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: %h %h, want 0", resp_rdata[0], resp_rdata[1]);
        end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; bit er, st, to; int lat;
        xfer(0, 1'b1, 64'd16, 64'h0123456789ABCDEF, 4'd8, rd, er, lat, st, to);
        model_write(16, 8, 64'h0123456789ABCDEF); model_last = 1'b0;
        n_checks++;
        if (to || er !== 1'b0 || rd !== 64'd0 || !st || lat != 1) begin
            n_fail++;
            $display("FAIL wr16: to=%b err=%b rdata=%h strobe=%b lat=%0d, want 0/0/0/1/1",
                     to, er, rd, st, lat);
        end
        xfer(0, 1'b0, 64'd16, 64'd0, 4'd8, rd, er, lat, st, to);
        n_checks++;
        if (to || rd !== model_read(16, 8) || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rd16: rdata=%h err=%b to=%b, want %h/0/0", rd, er, to, model_read(16, 8));
        end
        n_checks++;
        if (lat != 1 || !st) begin
            n_fail++;
            $display("FAIL rd16_timing: lat=%0d strobe=%b, want 1/1", lat, st);
        end
    endtask

    task automatic test_narrow_read();
        logic [63:0] rd; bit er, st, to; int lat;
        xfer(1, 1'b0, 64'd18, 64'd0, 4'd2, rd, er, lat, st, to);
        model_last = 1'b1;
        n_checks++;
        if (to || rd !== 64'h89AB || rd !== model_read(18, 2) || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rd18: rdata=%h err=%b to=%b, want 89ab/0/0", rd, er, to);
        end
    endtask

    task automatic test_round_robin();
        int g, r, cyc, o, exp_g;
        int owner_q[$];
        logic [63:0] e [2];
        e[0] = model_read(16, 8);
        e[1] = model_read(18, 2);
        set_req(0, 1'b0, 64'd16, 64'd0, 4'd8);
        set_req(1, 1'b0, 64'd18, 64'd0, 4'd2);
        resp_ready = 2'b11;
        req_valid  = 2'b11;
        exp_g = model_last ? 0 : 1;
        g = 0; r = 0; cyc = 0;
        #1;
        while ((g < 6 || r < 6) && cyc < 100) begin
            if (req_ready != 2'b00) begin
                n_checks++;
                if (req_ready !== (2'b01 << exp_g)) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: ready=%b, want %b", g, req_ready, 2'b01 << exp_g);
                end
                owner_q.push_back(req_ready[1] ? 1 : 0);
                model_last = req_ready[1];
                exp_g = 1 - exp_g;
                g++;
            end
            if (resp_valid != 2'b00) begin
                o = (owner_q.size() > 0) ? owner_q[0] : 0;
                n_checks++;
                if (resp_valid !== (2'b01 << o)) begin
                    n_fail++;
                    $display("FAIL rr_owner%0d: resp_valid=%b, want %b", r, resp_valid, 2'b01 << o);
                end
                n_checks++;
                if (resp_rdata[o] !== e[o]) begin
                    n_fail++;
                    $display("FAIL rr_rdata%0d: %h, want %h", r, resp_rdata[o], e[o]);
                end
                if (owner_q.size() > 0) void'(owner_q.pop_front());
                r++;
            end
            @(posedge clk); #1;
            if (g == 6) req_valid = 2'b00;
            #1;
            cyc++;
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;
        n_checks++;
        if (g != 6 || r != 6) begin
            n_fail++;
            $display("FAIL rr_timeout: grants=%0d resps=%0d, want 6/6", g, r);
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, wd, a; bit er, st, to; int lat, n, sz; bit we;
        for (int t = 0; t < 40; t++) begin
            n  = $urandom_range(0, 1);
            sz = 1 << $urandom_range(0, 3);
            a  = 64'($urandom_range(0, 1023) & ~(sz - 1));
            we = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            xfer(n, we, a, wd, 4'(sz), rd, er, lat, st, to);
            model_last = n[0];
            n_checks++;
            if (to || er !== 1'b0 || lat != 1 || !st) begin
                n_fail++;
                $display("FAIL rand%0d_flow: to=%b err=%b lat=%0d strobe=%b", t, to, er, lat, st);
            end
            n_checks++;
            if (we) begin
                if (rd !== 64'd0) begin
                    n_fail++;
                    $display("FAIL rand%0d_wr_rdata: %h, want 0", t, rd);
                end
                model_write(int'(a), sz, wd);
            end else if (rd !== model_read(int'(a), sz)) begin
                n_fail++;
                $display("FAIL rand%0d_rd a=%0d sz=%0d: %h, want %h",
                         t, a, sz, rd, model_read(int'(a), sz));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e; int k;
        e = model_read(16, 8);
        set_req(0, 1'b0, 64'd16, 64'd0, 4'd8);
        req_valid[0] = 1'b1;
        #1;
        k = 0;
        while (!req_ready[0] && k < 20) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 1'b0, 64'd24, 64'd0, 4'd4);
        req_valid[1] = 1'b1;
        k = 0;
        while (!resp_valid[0] && k < 20) begin
            @(posedge clk); #1; k++;
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (resp_valid !== 2'b01 || resp_rdata[0] !== e || req_ready[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d: rv=%b rdata=%h r1_ready=%b, want 01/%h/0",
                         c, resp_valid, resp_rdata[0], req_ready[1], e);
            end
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        req_valid[1] = 1'b0;
        model_last = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 2'b00 || mem_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL withdrawn_r1: rv=%b re=%b, want 00/0", resp_valid, mem_read_enable);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd; bit er, st, to; int lat;
`ifdef DMEM_ARB_CHECK_EN
        xfer(0, 1'b0, 64'd3, 64'd0, 4'd2, rd, er, lat, st, to);
        n_checks++;
        if (to || er !== 1'b1 || rd !== 64'd0 || st || lat != 0) begin
            n_fail++;
            $display("FAIL err_misalign: to=%b err=%b rdata=%h strobe=%b lat=%0d, want 0/1/0/0/0",
                     to, er, rd, st, lat);
        end
        xfer(1, 1'b0, 64'd1020, 64'd0, 4'd8, rd, er, lat, st, to);
        n_checks++;
        if (to || er !== 1'b1 || st) begin
            n_fail++;
            $display("FAIL err_range: to=%b err=%b strobe=%b, want 0/1/0", to, er, st);
        end
        xfer(0, 1'b1, 64'd0, 64'hFFFF_FFFF, 4'd3, rd, er, lat, st, to);
        n_checks++;
        if (to || er !== 1'b1 || st) begin
            n_fail++;
            $display("FAIL err_size3: to=%b err=%b strobe=%b, want 0/1/0", to, er, st);
        end
        model_last = 1'b0;
`else
        xfer(1, 1'b0, 64'd1020, 64'd0, 4'd8, rd, er, lat, st, to);
        model_last = 1'b1;
        n_checks++;
        if (to || er !== 1'b0 || !st || lat != 1) begin
            n_fail++;
            $display("FAIL nochk_range: to=%b err=%b strobe=%b lat=%0d, want 0/0/1/1",
                     to, er, st, lat);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        logic [63:0] prior, rd; bit er, st, to; int lat, k;
        prior = model_read(40, 1);
        set_req(0, 1'b1, 64'd40, 64'hFF, 4'd1);
        req_valid[0] = 1'b1;
        #1;
        k = 0;
        while (!req_ready[0] && k < 20) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++;
        if (mem_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access_we: %b, want 1", mem_write_enable);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (mem_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_drop: we=%b, want 0", mem_write_enable);
        end
        @(posedge clk); #1;
        test_reset();
        reset = 1'b0;
        model_last = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 64'd40, 64'd0, 4'd1, rd, er, lat, st, to);
        model_last = 1'b0;
        n_checks++;
        if (to || rd !== prior) begin
            n_fail++;
            $display("FAIL mid_reset_nowrite: rdata=%h to=%b, want %h", rd, to, prior);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_last = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        reset      = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_we     = 2'b00;
        for (int n = 0; n < 2; n++) set_req(n, 1'b0, 64'd0, 64'd0, 4'd8);
        #12;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_write_read();
        test_narrow_read();
        test_round_robin();
        test_random();
        test_backpressure();
        test_errors();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
